// File: rtl/pn_dac_tx.sv
// pn_dac_tx: transmit-side DAC interface for the Red Pitaya PN board.
// Accepts two-channel signed sample pairs over a valid/ready stream,
// saturates them to 14 bits, converts to offset binary and interleaves
// them onto the DAC bus over two AClk cycles. Also sequences DAC reset
// after power-up and counts stream underflows.
//
// Stream handshake: a pair (SCh1, SCh2) transfers on the AClk rising edge
// where SValid && SReady are both high. SReady depends only on internal
// state (RUN, phase 0, no stop pending), never on SValid. Once SValid is
// raised the source holds it and the data stable until the transfer edge.
module pn_dac_tx #(
  parameter int RST_CYCLES = 16,
  parameter int IN_W       = 16
) (
  input  logic            AClk,
  input  logic            ARstn,
  input  logic            En,
  input  logic [IN_W-1:0] SCh1,
  input  logic [IN_W-1:0] SCh2,
  input  logic            SValid,
  output logic            SReady,
  output logic [13:0]     DDat,
  output logic            DSel,
  output logic            DWrt,
  output logic            DRst,
  output logic [15:0]     UnderCnt,
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYCLES - 1);
  localparam logic [13:0] MID = 14'h2000;
  localparam logic signed [IN_W-1:0] C_MAX = IN_W'(8191);
  localparam logic signed [IN_W-1:0] C_MIN = IN_W'(-8192);

  state_t          r_state, w_state_nx;
  logic            r_phase, w_phase_nx;
  logic            r_stop, w_stop_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [13:0]     r_ch1, w_ch1_nx;
  logic [13:0]     r_ch2, w_ch2_nx;
  logic [13:0]     r_ddat, w_ddat_nx;
  logic            r_dsel, w_dsel_nx;
  logic            r_dwrt, w_dwrt_nx;
  logic            r_drst, w_drst_nx;
  logic [15:0]     r_under_cnt, w_under_nx;
  logic            w_sready;

  // Clip a signed sample to the 14-bit range, then flip the sign bit to
  // get offset binary (-8192 -> 0x0000, 0 -> 0x2000, +8191 -> 0x3FFF).
  function automatic logic [13:0] to_code(input logic [IN_W-1:0] s);
    logic signed [IN_W-1:0] v;
    logic [13:0]            r;
    v = $signed(s);
    if (v > C_MAX)      r = 14'h3FFF;
    else if (v < C_MIN) r = 14'h0000;
    else                r = {~v[13], v[12:0]};
    return r;
  endfunction

  // A pending stop blocks new pairs so the in-flight Ch2 word can finish.
  assign w_sready = (r_state == ST_RUN) && !r_phase && !r_stop;

  // Next-state and next-output logic for the RST/IDLE/RUN sequencer.
  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_stop_nx  = r_stop;
    w_cnt_nx   = r_cnt;
    w_ch1_nx   = r_ch1;
    w_ch2_nx   = r_ch2;
    w_ddat_nx  = MID;
    w_dsel_nx  = 1'b0;
    w_dwrt_nx  = 1'b0;
    w_under_nx = r_under_cnt;
    case (r_state)
      ST_RST: begin
        if (r_cnt == CNT_LAST) w_state_nx = ST_IDLE;
        else                   w_cnt_nx   = r_cnt + CW'(1);
      end
      ST_IDLE: begin
        // Clear the held Ch2 word so a restart opens with mid-scale.
        w_ch2_nx   = MID;
        w_phase_nx = 1'b0;
        w_stop_nx  = 1'b0;
        if (En) w_state_nx = ST_RUN;
      end
      ST_RUN: begin
        w_dwrt_nx = ~r_phase;
        w_stop_nx = r_stop | ~En;
        if (!r_phase) begin
          // Pair boundary: emit the held Ch2 word of the previous slot.
          w_ddat_nx = r_ch2;
          w_dsel_nx = 1'b0;
          if (r_stop) begin
            w_state_nx = ST_IDLE;
          end else if (SValid) begin
            w_ch1_nx   = to_code(SCh1);
            w_ch2_nx   = to_code(SCh2);
            w_phase_nx = 1'b1;
          end else if (En) begin
            w_ch1_nx   = MID;
            w_ch2_nx   = MID;
            w_phase_nx = 1'b1;
            if (r_under_cnt != 16'hFFFF) w_under_nx = r_under_cnt + 16'd1;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else begin
          w_ddat_nx  = r_ch1;
          w_dsel_nx  = 1'b1;
          w_phase_nx = 1'b0;
        end
      end
      default: w_state_nx = ST_RST;
    endcase
    w_drst_nx = (w_state_nx == ST_RST);
  end

  // State and output registers; ARstn forces the full reset sequence.
  always_ff @(posedge AClk or negedge ARstn) begin
    if (!ARstn) begin
      r_state     <= ST_RST;
      r_phase     <= 1'b0;
      r_stop      <= 1'b0;
      r_cnt       <= '0;
      r_ch1       <= MID;
      r_ch2       <= MID;
      r_ddat      <= MID;
      r_dsel      <= 1'b0;
      r_dwrt      <= 1'b0;
      r_drst      <= 1'b1;
      r_under_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nx;
      r_phase     <= w_phase_nx;
      r_stop      <= w_stop_nx;
      r_cnt       <= w_cnt_nx;
      r_ch1       <= w_ch1_nx;
      r_ch2       <= w_ch2_nx;
      r_ddat      <= w_ddat_nx;
      r_dsel      <= w_dsel_nx;
      r_dwrt      <= w_dwrt_nx;
      r_drst      <= w_drst_nx;
      r_under_cnt <= w_under_nx;
    end
  end

  assign SReady      = w_sready;
  assign DDat        = r_ddat;
  assign DSel        = r_dsel;
  assign DWrt        = r_dwrt;
  assign DRst        = r_drst;
  assign UnderCnt    = r_under_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pn_dac_tx.sv
// Bench for pn_dac_tx: directed sequence plus randomized pair stream,
// checked against a queue of expected bus words.
module tb_pn_dac_tx;

  localparam int RST_CYCLES = 4;
  localparam int IN_W       = 16;
  localparam logic [13:0] MID = 14'h2000;

  logic            AClk = 1'b0;
  logic            ARstn;
  logic            En;
  logic [IN_W-1:0] SCh1;
  logic [IN_W-1:0] SCh2;
  logic            SValid;
  logic            SReady;
  logic [13:0]     DDat;
  logic            DSel;
  logic            DWrt;
  logic            DRst;
  logic [15:0]     UnderCnt;
  logic [1:0]      dbg_state;

  int errors = 0;
  int checks = 0;
  int under_exp = 0;
  // Each entry: {dwrt, dsel, ddat[13:0]}
  logic [15:0] exp_q[$];

  pn_dac_tx #(.RST_CYCLES(RST_CYCLES), .IN_W(IN_W)) dut (
    .AClk(AClk), .ARstn(ARstn), .En(En), .SCh1(SCh1), .SCh2(SCh2),
    .SValid(SValid), .SReady(SReady), .DDat(DDat), .DSel(DSel),
    .DWrt(DWrt), .DRst(DRst), .UnderCnt(UnderCnt), .o_dbg_state(dbg_state)
  );

  // Clock
  always #5 AClk = ~AClk;

  // Reference conversion: clamp the integer value, then add the offset.
  function automatic logic [13:0] model_code(input logic [15:0] s);
    int v;
    v = int'($signed(s));
    if (v > 8191)  v = 8191;
    if (v < -8192) v = -8192;
    return 14'(v + 8192);
  endfunction

  function automatic logic [15:0] rnd_sample();
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0:       return 16'($urandom);
      1:       return 16'($urandom_range(0, 16383) - 8192);
      2:       return 16'(8189 + $urandom_range(0, 5));
      default: return 16'(-8195 + $urandom_range(0, 5));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled at negedge.
  task automatic step();
    @(posedge AClk);
    @(negedge AClk);
  endtask

  task automatic check_word(input string tag);
    logic [15:0] w;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=queue_empty", tag, DDat);
    end else begin
      w = exp_q.pop_front();
      chk({tag, "_ddat"}, 32'(DDat), 32'(w[13:0]));
      chk({tag, "_dsel"}, 32'(DSel), 32'(w[14]));
      chk({tag, "_dwrt"}, 32'(DWrt), 32'(w[15]));
    end
  endtask

  task automatic push_pair(input logic [13:0] c1, input logic [13:0] c2);
    exp_q.push_back({1'b0, 1'b1, c1});
    exp_q.push_back({1'b1, 1'b0, c2});
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ddat"}, 32'(DDat), 32'(MID));
    chk({tag, "_dsel"}, 32'(DSel), 32'd0);
    chk({tag, "_dwrt"}, 32'(DWrt), 32'd0);
    chk({tag, "_srdy"}, 32'(SReady), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_idle(tag);
    chk({tag, "_drst"}, 32'(DRst), 32'd1);
    chk({tag, "_under"}, 32'(UnderCnt), 32'd0);
  endtask

  // After ARstn release: DRst stays high for exactly RST_CYCLES edges.
  task automatic rst_release();
    ARstn = 1'b1;
    chk("drst_pre", 32'(DRst), 32'd1);
    for (int e = 1; e <= RST_CYCLES; e++) begin
      step();
      chk("drst_seq", 32'(DRst), 32'(e < RST_CYCLES));
      check_idle("rst_seq");
    end
    exp_q.delete();
    under_exp = 0;
  endtask

  // From IDLE: one edge with En high enters RUN; the first pair boundary
  // emits a mid-scale channel-2 word.
  task automatic enter_run();
    En = 1'b1;
    step();
    chk("enter_srdy", 32'(SReady), 32'd1);
    chk("enter_ddat", 32'(DDat), 32'(MID));
    chk("enter_dwrt", 32'(DWrt), 32'd0);
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, MID});
  endtask

  // One pair slot (two cycles) while running; valid=0 requires en0=1.
  task automatic slot(input logic valid, input logic [15:0] c1, input logic [15:0] c2,
                      input logic en0, input logic en1);
    chk("slot_srdy0", 32'(SReady), 32'd1);
    En = en0; SValid = valid; SCh1 = c1; SCh2 = c2;
    step();
    if (valid) push_pair(model_code(c1), model_code(c2));
    else begin
      push_pair(MID, MID);
      if (under_exp < 65535) under_exp++;
    end
    check_word("ch2_word");
    chk("slot_srdy1", 32'(SReady), 32'd0);
    chk("under_cnt", 32'(UnderCnt), 32'(under_exp));
    SValid = 1'b0; SCh1 = 16'($urandom); SCh2 = 16'($urandom); En = en1;
    step();
    check_word("ch1_word");
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    ARstn = 1'b1; En = 1'b1; SValid = 1'b0; SCh1 = '0; SCh2 = '0;
    #2 ARstn = 1'b0;
    #1 check_reset_vals("reset");
    @(negedge AClk);
    @(negedge AClk);

    // Reset sequence with En held high
    rst_release();
    enter_run();

    // Underflow: three empty pair slots
    for (int i = 0; i < 3; i++) slot(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("under_three", 32'(UnderCnt), 32'd3);

    // Nominal stream and saturation
    slot(1'b1, 16'd0, 16'd0, 1'b1, 1'b1);
    slot(1'b1, 16'd100, 16'hFF9C, 1'b1, 1'b1);
    slot(1'b1, 16'd8191, 16'hE000, 1'b1, 1'b1);
    slot(1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
    slot(1'b1, 16'h2000, 16'hDFFF, 1'b1, 1'b1);

    // Randomized stream with occasional gaps
    for (int i = 0; i < 40; i++) begin
      a = rnd_sample();
      b = rnd_sample();
      slot(($urandom_range(0, 7) != 0), a, b, 1'b1, 1'b1);
    end

    // Disable one cycle after a handshake: Ch2 still completes, then idle
    slot(1'b1, 16'd1234, 16'hF000, 1'b1, 1'b0);
    chk("dis_srdy", 32'(SReady), 32'd0);
    SValid = 1'b1; SCh1 = 16'd77; SCh2 = 16'd88;
    step();
    check_word("dis_ch2");
    chk("dis_srdy2", 32'(SReady), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("dis_idle");
    end
    SValid = 1'b0;
    chk("dis_under", 32'(UnderCnt), 32'(under_exp));

    // En falls on the handshake edge: pair accepted and completed
    enter_run();
    chk("sim_srdy", 32'(SReady), 32'd1);
    a = rnd_sample(); b = rnd_sample();
    En = 1'b0; SValid = 1'b1; SCh1 = a; SCh2 = b;
    step();
    push_pair(model_code(a), model_code(b));
    check_word("sim_prev");
    chk("sim_srdy1", 32'(SReady), 32'd0);
    SValid = 1'b0;
    step();
    check_word("sim_ch1");
    chk("sim_srdy2", 32'(SReady), 32'd0);
    step();
    check_word("sim_ch2");
    step();
    check_idle("sim_idle");

    // En low on an empty pair boundary: no underflow counted
    enter_run();
    En = 1'b0;
    step();
    check_word("empty_stop");
    step();
    check_idle("empty_idle");
    chk("empty_under", 32'(UnderCnt), 32'(under_exp));

    // Counter saturation, starting near the top
    force dut.r_under_cnt = 16'hFFFD;
    step();
    release dut.r_under_cnt;
    under_exp = 65533;
    enter_run();
    for (int i = 0; i < 4; i++) slot(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("under_sat", 32'(UnderCnt), 32'hFFFF);

    // Async reset while the Ch1 word is on the bus
    a = 16'd4000; b = 16'hC000;
    chk("ar_srdy", 32'(SReady), 32'd1);
    SValid = 1'b1; SCh1 = a; SCh2 = b;
    step();
    push_pair(model_code(a), model_code(b));
    check_word("ar_prev");
    SValid = 1'b0;
    step();
    check_word("ar_ch1");
    #2 ARstn = 1'b0;
    #1 check_reset_vals("ar_async");
    @(negedge AClk);
    check_reset_vals("ar_hold");
    rst_release();
    enter_run();
    slot(1'b1, 16'd5, 16'hFFFB, 1'b1, 1'b1);
    chk("ar_under", 32'(UnderCnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pn_dac_tx.md
# pn_dac_tx

Transmit-side DAC interface for the Red Pitaya PN board: the output counterpart of the ADC clock/capture path. It accepts two-channel signed sample pairs over a valid/ready stream and drives the interleaved 14-bit DAC bus. The DAC bus signals are data, select, write and reset. Each stored pair is saturated, converted to offset binary and time-multiplexed onto the bus over two clock cycles. The block also sequences the DAC reset after power-up and counts stream underflows.

## Interface
- RST_CYCLES, 16: cycles DRst is held high after reset release.
- IN_W, 16: input sample width, signed two's complement, IN_W >= 14.
- AClk  in  1  sample-domain clock, the buffered ADC clock (BUFG output), 2x pair rate.
- ARstn  in  1  asynchronous active-low reset.
- En  in  1  run enable; level-sensitive.
- SCh1  in  IN_W  channel-1 sample, signed.
- SCh2  in  IN_W  channel-2 sample, signed.
- SValid  in  1  pair valid.
- SReady  out  1  pair accepted when SValid & SReady at the AClk rising edge.
- DDat  out  14  DAC data, offset binary, registered.
- DSel  out  1  1 = DDat carries channel 1; 0 = channel 2.
- DWrt  out  1  DAC write strobe, registered.
- DRst  out  1  DAC reset, active-high, registered.
- UnderCnt  out  16  saturating count of missed pairs.

## Operation
- States: RST, IDLE, RUN.
  - RST: entered on ARstn low. DRst=1. Counter runs 0..RST_CYCLES-1 after ARstn deasserts, then the block goes to IDLE and DRst=0.
  - IDLE: DDat=14'h2000 (mid-scale), DSel=0, DWrt=0, SReady=0. En=1 moves to RUN with phase=0 on the next edge.
  - RUN: 1-bit phase toggles every cycle.
    - Phase 0: SReady=1.
    - Phase 1: SReady=0.
- Conversion per channel:
  - Clip to [-8192, +8191]: values above clip to +8191 and values below clip to -8192. No shifting is applied.
  - Then invert bit 13: -8192 -> 14'h0000, 0 -> 14'h2000, +8191 -> 14'h3FFF.
- Pair path:
  - On a phase-0 handshake, Ch1 code goes to DDat with DSel=1 in the next cycle.
  - The Ch2 code is held in a register and goes to DDat with DSel=0 in the following cycle.
- Underflow: phase 0 with SValid=0 means the pair slot outputs 14'h2000 on both channels, DSel sequence unchanged. UnderCnt increments by 1 and saturates at 16'hFFFF.
- DWrt:
  - In RUN, DWrt = registered ~phase, so it goes high in the cycle after each DDat update (mid-word).
  - Outside RUN, DWrt=0.
- En low in RUN:
  - If the Ch1 word is on the bus, the Ch2 word still completes.
  - The block then returns to IDLE at a pair boundary.
  - No new pair is accepted once En is sampled low in phase 0.
- UnderCnt is cleared only by ARstn. It does not count in IDLE or RST.

## Timing
- Reset values (ARstn low, asynchronous):
  - DDat=14'h2000, DSel=0, DWrt=0, DRst=1, SReady=0, UnderCnt=0.
  - State=RST, phase=0, counter=0.
- DRst falls exactly RST_CYCLES edges after the first edge with ARstn high.
- En=1 in IDLE at edge N gives SReady=1 during cycle N+1, which is the first phase 0.
- Handshake at edge k (phase 0):
  - After edge k+1: DDat=Ch1 code, DSel=1.
  - After edge k+2: DDat=Ch2 code, DSel=0.
  - Pipeline latency is 1 cycle to Ch1 and 2 cycles to Ch2.
- Sustained throughput is one pair per 2 cycles. SReady is never high on consecutive cycles.
- SReady is combinational from state/phase only, never from SValid. Samples are captured only on the handshake edge.
- Simultaneous En fall and handshake in phase 0: the pair is accepted and completed, then the block goes to IDLE.
- ARstn low mid-pair: outputs go immediately to their reset values and the held Ch2 word is discarded. The full RST sequence reruns.

## Test plan
- Reset sequence:
  - Stimulus: RST_CYCLES=4; release ARstn; hold En=1.
  - Response: DRst=1 for exactly 4 edges, then 0. SReady first high one cycle after IDLE is entered. DDat=14'h2000 throughout.
- Nominal stream:
  - Stimulus: pairs (0,0), (100,-100), (8191,-8192) back-to-back.
  - Response: DDat/DSel sequence 2000/1, 2000/0, 2064/1, 1F9C/0, 3FFF/1, 0000/0. DWrt toggles 0,1,0,1 in RUN. UnderCnt=0.
- Saturation:
  - Stimulus: Ch1=16'h7FFF, Ch2=16'h8000.
  - Response: DDat=14'h3FFF then 14'h0000.
- Underflow:
  - Stimulus: SValid low for 3 phase-0 slots.
  - Response: 6 mid-scale words, DSel still alternating 1,0, UnderCnt=3. A forced 65536 underflows leave UnderCnt=16'hFFFF.
- Disable:
  - Stimulus: drop En in the cycle after a handshake.
  - Response: the Ch2 word still appears, then IDLE with DDat=14'h2000 and DWrt=0. No further SReady.
- Async reset mid-pair:
  - Stimulus: assert ARstn low while the Ch1 word is on the bus.
  - Response: outputs go to reset values without waiting for an AClk edge. The Ch2 word is never emitted. DRst=1.
